inst_fetch_q: RTL and testbench

Parametrised instruction-fetch unit with a prefetch queue, successor to the multi-cycle fetch stage. It issues sequential instruction reads over a request/acknowledge memory handshake and buffers up to DEPTH fetched instructions with their next-PC values. It presents them to decode through a valid/ready interface. Taken-branch redirects (COND with the ULA target) flush the queue, and an in-flight read is discarded safely.

---
 rtl/ifetch_pkg.sv | 26 ++
 rtl/ifetch_fifo.sv | 61 ++++++
 rtl/inst_fetch_q.sv | 156 +++++++++++++++
 tb/tb_inst_fetch_q.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared state encoding and width/alignment helpers for inst_fetch_q.
package ifetch_pkg;

   localparam int unsigned ESTADO_W = 2;

   typedef enum logic [ESTADO_W-1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_FAULT = 2'd3
   } ifetch_state_t;

   function automatic int unsigned inc_bytes(input int unsigned inst_w);
      return inst_w / 8;
   endfunction

   // Low PC bits that must be zero for an instruction-aligned address.
   function automatic int unsigned align_mask(input int unsigned inst_w);
      return (inst_w / 8) - 1;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous first-word-fall-through FIFO for fetched {instruction, next-PC} pairs.
// Flush has priority over push; the head word is read straight from storage.
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter int unsigned       WIDTH      = 48,
   parameter int unsigned       DEPTH      = 4,
   parameter logic [WIDTH-1:0]  RESET_WORD = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic                      pop,
   input  logic                      flush,
   input  logic [WIDTH-1:0]          din,
   output logic [WIDTH-1:0]          dout,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic                      full,
   output logic                      empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = cnt_w(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[PTR_W'(i)] <= RESET_WORD;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/inst_fetch_q.sv
// inst_fetch_q: sequential instruction fetch with a prefetch queue and branch redirect/drain handling.
// Define IFETCH_ALIGN_CHECK_EN to trap misaligned redirect targets into the FAULT state.
module inst_fetch_q
   import ifetch_pkg::*;
#(
   parameter int unsigned        ADDR_W   = 16,
   parameter int unsigned        INST_W   = 32,
   parameter int unsigned        DEPTH    = 4,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic                 CLK,
   input  logic                 RST,
   output logic                 MEM_REQ,
   output logic [ADDR_W-1:0]    MEM_ADDR,
   input  logic                 MEM_ACK,
   input  logic [INST_W-1:0]    MEM_OUT,
   input  logic                 COND,
   input  logic [ADDR_W-1:0]    ULA,
   output logic [INST_W-1:0]    IR,
   output logic [ADDR_W-1:0]    NPC,
   output logic                 IR_VALID,
   input  logic                 IR_READY,
   output logic [ESTADO_W-1:0]  ESTADO,
   output logic                 FAULT
);

   localparam int unsigned       CNT_W   = cnt_w(DEPTH);
   localparam int unsigned       ENT_W   = INST_W + ADDR_W;
   localparam logic [ADDR_W-1:0] INC_A   = ADDR_W'(inc_bytes(INST_W));
   localparam logic [ADDR_W-1:0] AL_MASK = ADDR_W'(align_mask(INST_W));

   ifetch_state_t     state, state_n;
   logic [ADDR_W-1:0] fetch_pc, pc_n, mem_addr_n, target;
   logic              mem_req_n, push, pop, flush, xfer, stalled, trap;
   logic              fault_pend, fault_pend_n;
   logic [CNT_W-1:0]  count, count_n;
   logic              fifo_full, fifo_empty;
   logic [ENT_W-1:0]  head;

   assign target = ULA & ~AL_MASK;

`ifdef IFETCH_ALIGN_CHECK_EN
   assign trap  = COND && ((ULA & AL_MASK) != '0);
   assign FAULT = (state == S_FAULT);
`else
   assign trap  = 1'b0;
   assign FAULT = 1'b0;
`endif

   assign IR_VALID = !fifo_empty;
   assign pop      = IR_VALID && IR_READY;
   assign IR       = head[ENT_W-1 -: INST_W];
   assign NPC      = head[ADDR_W-1:0];
   assign ESTADO   = state;

   ifetch_fifo #(
      .WIDTH      (ENT_W),
      .DEPTH      (DEPTH),
      .RESET_WORD ({{INST_W{1'b0}}, RESET_PC})
   ) u_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   ({MEM_OUT, fetch_pc + INC_A}),
      .dout  (head),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_n      = state;
      pc_n         = fetch_pc;
      push         = 1'b0;
      flush        = 1'b0;
      fault_pend_n = fault_pend;
      xfer         = MEM_REQ && MEM_ACK;
      stalled      = MEM_REQ && !MEM_ACK;

      case (state)
         S_IDLE: begin
            if (COND) pc_n = target;
            state_n = trap ? S_FAULT : S_RUN;
         end
         S_RUN: begin
            if (COND) begin
               flush = 1'b1;
               pc_n  = target;
               // An unacked request must still complete before new addresses go out.
               if (stalled) begin
                  state_n      = S_DRAIN;
                  fault_pend_n = trap;
               end else if (trap) begin
                  state_n = S_FAULT;
               end
            end else if (xfer) begin
               push = !fifo_full;
               pc_n = fetch_pc + INC_A;
            end
         end
         S_DRAIN: begin
            flush = COND;
            if (COND) pc_n = target;
            if (trap) fault_pend_n = 1'b1;
            if (MEM_ACK) begin
               state_n      = (fault_pend || trap) ? S_FAULT : S_RUN;
               fault_pend_n = 1'b0;
            end
         end
         S_FAULT: begin
            state_n = S_FAULT;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      count_n = count;
      if (flush) begin
         count_n = '0;
      end else begin
         count_n = count + CNT_W'(push) - CNT_W'(pop);
      end

      // Request/address are registered so they stay stable until the ack.
      mem_req_n  = 1'b0;
      mem_addr_n = pc_n;
      case (state_n)
         S_RUN:   mem_req_n = (count_n < CNT_W'(DEPTH));
         S_DRAIN: begin
            mem_req_n  = 1'b1;
            mem_addr_n = MEM_ADDR;
         end
         default: mem_req_n = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= S_IDLE;
         fetch_pc   <= RESET_PC;
         MEM_REQ    <= 1'b0;
         MEM_ADDR   <= RESET_PC;
         fault_pend <= 1'b0;
      end else begin
         state      <= state_n;
         fetch_pc   <= pc_n;
         MEM_REQ    <= mem_req_n;
         MEM_ADDR   <= mem_addr_n;
         fault_pend <= fault_pend_n;
      end
   end

endmodule

// File: tb/tb_inst_fetch_q.sv
// tb_inst_fetch_q: directed vector table, corner sequences and randomized run against a queue model.
module tb_inst_fetch_q;

   localparam int unsigned DEPTH = 4;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        MEM_REQ;
   logic [15:0] MEM_ADDR;
   logic        MEM_ACK = 1'b0;
   logic [31:0] MEM_OUT;
   logic        COND = 1'b0;
   logic [15:0] ULA = 16'h0000;
   logic [31:0] IR;
   logic [15:0] NPC;
   logic        IR_VALID;
   logic        IR_READY = 1'b0;
   logic [1:0]  ESTADO;
   logic        FAULT;

   logic        tbl_data = 1'b1;
   logic [31:0] rdata = 32'h0;

   int total = 0;
   int bad   = 0;

   // Directed phases return addr^0xA5A5_0000; the random phase supplies arbitrary data.
   assign MEM_OUT = tbl_data ? {16'hA5A5, MEM_ADDR} : rdata;

   always #5 CLK = ~CLK;

   inst_fetch_q #(
      .ADDR_W   (16),
      .INST_W   (32),
      .DEPTH    (DEPTH),
      .RESET_PC (16'h0000)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .MEM_REQ  (MEM_REQ),
      .MEM_ADDR (MEM_ADDR),
      .MEM_ACK  (MEM_ACK),
      .MEM_OUT  (MEM_OUT),
      .COND     (COND),
      .ULA      (ULA),
      .IR       (IR),
      .NPC      (NPC),
      .IR_VALID (IR_VALID),
      .IR_READY (IR_READY),
      .ESTADO   (ESTADO),
      .FAULT    (FAULT)
   );

   typedef struct {
      logic        cond;
      logic [15:0] ula;
      logic        ack;
      logic        rdy;
      logic        e_req;
      logic [15:0] e_addr;
      logic        e_valid;
      logic [15:0] e_npc;
      logic [1:0]  e_st;
   } vec_t;

   typedef struct packed {
      logic [31:0] ir;
      logic [15:0] npc;
   } ent_t;

   vec_t tbl [21];

   // Reference model: queue of fetched entries plus the fetch pointer and outstanding request.
   int          m_mode;
   logic [15:0] m_pc;
   logic [15:0] m_addr;
   logic        m_req;
   ent_t        m_q [$];

   function automatic vec_t mk(input logic c, input logic [15:0] u, input logic a, input logic r,
                               input logic q, input logic [15:0] ad, input logic v,
                               input logic [15:0] n, input logic [1:0] s);
      vec_t t;
      t.cond = c; t.ula = u; t.ack = a; t.rdy = r;
      t.e_req = q; t.e_addr = ad; t.e_valid = v; t.e_npc = n; t.e_st = s;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      COND = 1'b0; ULA = 16'h0000; MEM_ACK = 1'b0; IR_READY = 1'b0;
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
   endtask

   task automatic model_reset();
      m_mode = 0; m_pc = 16'h0000; m_addr = 16'h0000; m_req = 1'b0;
      m_q.delete();
   endtask

   task automatic model_edge(input logic cond, input logic [15:0] ula, input logic ack,
                             input logic [31:0] mout, input logic rdy);
      logic [15:0] tgt;
      ent_t        e;
      tgt = ula & 16'hFFFC;
      if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
      case (m_mode)
         0: begin
            m_mode = 1;
            if (cond) m_pc = tgt;
         end
         1: begin
            if (cond) begin
               m_q.delete();
               m_pc = tgt;
               if (m_req && !ack) m_mode = 2;
            end else if (m_req && ack) begin
               e.ir  = mout;
               e.npc = m_pc + 16'd4;
               m_q.push_back(e);
               m_pc = m_pc + 16'd4;
            end
         end
         default: begin
            if (cond) m_pc = tgt;
            if (ack) m_mode = 1;
         end
      endcase
      m_req = (m_mode == 2) || (m_mode == 1 && m_q.size() < DEPTH);
      if (m_mode != 2) m_addr = m_pc;
   endtask

   initial begin
      logic        c_r, a_r, r_r;
      logic [15:0] u_r;

      tbl[0]  = mk(1'b0, 16'h0000, 1'b1, 1'b0,  1'b1, 16'h0000, 1'b0, 16'h0000, 2'd1);
      tbl[1]  = mk(1'b0, 16'h0000, 1'b1, 1'b0,  1'b1, 16'h0004, 1'b1, 16'h0004, 2'd1);
      tbl[2]  = mk(1'b0, 16'h0000, 1'b1, 1'b0,  1'b1, 16'h0008, 1'b1, 16'h0004, 2'd1);
      tbl[3]  = mk(1'b0, 16'h0000, 1'b1, 1'b0,  1'b1, 16'h000C, 1'b1, 16'h0004, 2'd1);
      tbl[4]  = mk(1'b0, 16'h0000, 1'b1, 1'b0,  1'b0, 16'h0010, 1'b1, 16'h0004, 2'd1);
      tbl[5]  = mk(1'b0, 16'h0000, 1'b1, 1'b0,  1'b0, 16'h0010, 1'b1, 16'h0004, 2'd1);
      tbl[6]  = mk(1'b0, 16'h0000, 1'b1, 1'b1,  1'b1, 16'h0010, 1'b1, 16'h0008, 2'd1);
      tbl[7]  = mk(1'b0, 16'h0000, 1'b1, 1'b1,  1'b1, 16'h0014, 1'b1, 16'h000C, 2'd1);
      tbl[8]  = mk(1'b0, 16'h0000, 1'b1, 1'b1,  1'b1, 16'h0018, 1'b1, 16'h0010, 2'd1);
      tbl[9]  = mk(1'b0, 16'h0000, 1'b1, 1'b1,  1'b1, 16'h001C, 1'b1, 16'h0014, 2'd1);
      tbl[10] = mk(1'b1, 16'h0100, 1'b1, 1'b1,  1'b1, 16'h0100, 1'b0, 16'h0000, 2'd1);
      tbl[11] = mk(1'b0, 16'h0000, 1'b1, 1'b1,  1'b1, 16'h0104, 1'b1, 16'h0104, 2'd1);
      tbl[12] = mk(1'b0, 16'h0000, 1'b1, 1'b0,  1'b1, 16'h0108, 1'b1, 16'h0104, 2'd1);
      tbl[13] = mk(1'b0, 16'h0000, 1'b0, 1'b0,  1'b1, 16'h0108, 1'b1, 16'h0104, 2'd1);
      tbl[14] = mk(1'b1, 16'h0200, 1'b0, 1'b0,  1'b1, 16'h0108, 1'b0, 16'h0000, 2'd2);
      tbl[15] = mk(1'b0, 16'h0000, 1'b0, 1'b0,  1'b1, 16'h0108, 1'b0, 16'h0000, 2'd2);
      tbl[16] = mk(1'b0, 16'h0000, 1'b1, 1'b1,  1'b1, 16'h0200, 1'b0, 16'h0000, 2'd1);
      tbl[17] = mk(1'b0, 16'h0000, 1'b1, 1'b1,  1'b1, 16'h0204, 1'b1, 16'h0204, 2'd1);
      tbl[18] = mk(1'b1, 16'hFFFC, 1'b1, 1'b1,  1'b1, 16'hFFFC, 1'b0, 16'h0000, 2'd1);
      tbl[19] = mk(1'b0, 16'h0000, 1'b1, 1'b1,  1'b1, 16'h0000, 1'b1, 16'h0000, 2'd1);
      tbl[20] = mk(1'b0, 16'h0000, 1'b1, 1'b1,  1'b1, 16'h0004, 1'b1, 16'h0004, 2'd1);

      // Reset values
      tick();
      tick();
      chk("rst estado",   32'(ESTADO),   32'd0);
      chk("rst mem_req",  32'(MEM_REQ),  32'd0);
      chk("rst mem_addr", 32'(MEM_ADDR), 32'h0);
      chk("rst ir",       IR,            32'h0);
      chk("rst npc",      32'(NPC),      32'h0);
      chk("rst ir_valid", 32'(IR_VALID), 32'd0);
      chk("rst fault",    32'(FAULT),    32'd0);

      // Stream, back-pressure, redirects, drain and wrap
      do_reset();
      for (int i = 0; i < 21; i++) begin
         COND = tbl[i].cond; ULA = tbl[i].ula; MEM_ACK = tbl[i].ack; IR_READY = tbl[i].rdy;
         tick();
         chk($sformatf("v%0d mem_req", i),  32'(MEM_REQ),  32'(tbl[i].e_req));
         chk($sformatf("v%0d mem_addr", i), 32'(MEM_ADDR), 32'(tbl[i].e_addr));
         chk($sformatf("v%0d ir_valid", i), 32'(IR_VALID), 32'(tbl[i].e_valid));
         chk($sformatf("v%0d estado", i),   32'(ESTADO),   32'(tbl[i].e_st));
         if (tbl[i].e_valid) begin
            chk($sformatf("v%0d npc", i), 32'(NPC), 32'(tbl[i].e_npc));
            chk($sformatf("v%0d ir", i),  IR, {16'hA5A5, tbl[i].e_npc - 16'd4});
         end
      end

      // Misaligned redirect target
      COND = 1'b1; ULA = 16'h0102; MEM_ACK = 1'b1; IR_READY = 1'b1;
      tick();
`ifdef IFETCH_ALIGN_CHECK_EN
      chk("align fault",    32'(FAULT),    32'd1);
      chk("align estado",   32'(ESTADO),   32'd3);
      chk("align mem_req",  32'(MEM_REQ),  32'd0);
      chk("align ir_valid", 32'(IR_VALID), 32'd0);
      ULA = 16'h0200;
      tick();
      COND = 1'b0;
      tick();
      chk("fault sticky estado",  32'(ESTADO),  32'd3);
      chk("fault sticky mem_req", 32'(MEM_REQ), 32'd0);
`else
      chk("align estado",   32'(ESTADO),   32'd1);
      chk("align mem_addr", 32'(MEM_ADDR), 32'h0100);
      chk("align mem_req",  32'(MEM_REQ),  32'd1);
      chk("align fault",    32'(FAULT),    32'd0);
      COND = 1'b0;
      tick();
      chk("align ir_valid", 32'(IR_VALID), 32'd1);
      chk("align npc",      32'(NPC),      32'h0104);
`endif

      // Asynchronous reset abandons a pending request
      do_reset();
      MEM_ACK = 1'b0;
      tick();
      tick();
      chk("pend mem_req",  32'(MEM_REQ),  32'd1);
      chk("pend mem_addr", 32'(MEM_ADDR), 32'h0);
      RST = 1'b1;
      #2;
      chk("async mem_req",  32'(MEM_REQ), 32'd0);
      chk("async estado",   32'(ESTADO),  32'd0);
      chk("async ir_valid", 32'(IR_VALID), 32'd0);

      // Redirect taken while still in IDLE
      tick();
      COND = 1'b1; ULA = 16'h0040; MEM_ACK = 1'b1; IR_READY = 1'b1;
      RST = 1'b0;
      tick();
      chk("idle redirect estado",   32'(ESTADO),   32'd1);
      chk("idle redirect mem_addr", 32'(MEM_ADDR), 32'h0040);
      chk("idle redirect mem_req",  32'(MEM_REQ),  32'd1);
      COND = 1'b0;
      tick();
      chk("idle redirect npc", 32'(NPC), 32'h0044);
      chk("idle redirect ir",  IR,       32'hA5A5_0040);

      // Randomized traffic against the reference model
      tbl_data = 1'b0;
      do_reset();
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         c_r = ($urandom_range(0, 15) == 0);
         u_r = 16'($urandom) & 16'hFFFC;
         if ($urandom_range(0, 3) == 0) u_r = 16'hFFF0 | (u_r & 16'h000C);
         a_r = ($urandom_range(0, 2) != 0);
         r_r = ($urandom_range(0, 3) != 0);
         COND = c_r; ULA = u_r; MEM_ACK = a_r; IR_READY = r_r;
         rdata = $urandom;
         @(posedge CLK);
         model_edge(c_r, u_r, a_r, rdata, r_r);
         #1;
         chk("rnd mem_req",  32'(MEM_REQ),  32'(m_req));
         chk("rnd mem_addr", 32'(MEM_ADDR), 32'(m_addr));
         chk("rnd estado",   32'(ESTADO),   32'(m_mode));
         chk("rnd ir_valid", 32'(IR_VALID), 32'(m_q.size() > 0));
         chk("rnd fault",    32'(FAULT),    32'd0);
         if (m_q.size() > 0) begin
            chk("rnd ir",  IR,       m_q[0].ir);
            chk("rnd npc", 32'(NPC), 32'(m_q[0].npc));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
